// File: rtl/ddr2_req_queue.sv
// Host request FIFO in front of the DDR2 controller c_* port: buffers read/write
// requests, issues them one at a time as single-cycle pulses and returns read data in order.
module ddr2_req_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 26,
   parameter int DATA_W = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    h_valid,
   output logic                    h_ready,
   input  logic                    h_we,
   input  logic [ADDR_W-1:0]       h_addr,
   input  logic [DATA_W-1:0]       h_wdata,
   output logic                    h_rvalid,
   output logic [DATA_W-1:0]       h_rdata,
   output logic [$clog2(DEPTH):0]  q_count,
   output logic [ADDR_W-1:0]       c_addr,
   output logic [DATA_W-1:0]       c_data_in,
   output logic                    c_rd_req,
   output logic                    c_wr_req,
   input  logic                    c_rdy,
   input  logic [DATA_W-1:0]       c_data_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic              we_mem   [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              ready_reg;
   logic [2:0]        wait_cnt_reg;
   logic              reissued_reg;
   logic              inflight_we_reg;
   logic              c_rd_req_reg, c_wr_req_reg;
   logic [ADDR_W-1:0] c_addr_reg;
   logic [DATA_W-1:0] c_data_in_reg;
   logic              h_rvalid_reg;
   logic [DATA_W-1:0] h_rdata_reg;

   logic enq, issue, reissue, done;

   assign enq = h_valid && ready_reg;

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      reissue    = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0 && c_rdy) begin
               issue      = 1'b1;
               state_next = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!c_rdy) begin
               state_next = WAIT_DONE;
            end else if (wait_cnt_reg == 3'd7 && !reissued_reg) begin
               // Controller missed the pulse for 8 cycles: repeat it once.
               reissue = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (c_rdy) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      count_next = count_reg;
      if (enq && !issue) begin
         count_next = count_reg + CNT_W'(1);
      end else if (!enq && issue) begin
         count_next = count_reg - CNT_W'(1);
      end
   end

   // Queue storage has no reset; the pointers alone define its contents.
   always_ff @(posedge clk) begin
      if (enq && rst_n) begin
         we_mem[wr_ptr_reg]   <= h_we;
         addr_mem[wr_ptr_reg] <= h_addr;
         data_mem[wr_ptr_reg] <= h_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         ready_reg       <= 1'b0;
         wait_cnt_reg    <= '0;
         reissued_reg    <= 1'b0;
         inflight_we_reg <= 1'b0;
         c_rd_req_reg    <= 1'b0;
         c_wr_req_reg    <= 1'b0;
         c_addr_reg      <= '0;
         c_data_in_reg   <= '0;
         h_rvalid_reg    <= 1'b0;
         h_rdata_reg     <= '0;
      end else begin
         count_reg <= count_next;
         ready_reg <= (count_next != CNT_W'(DEPTH));
         if (enq) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end

         c_rd_req_reg <= (issue && !we_mem[rd_ptr_reg]) || (reissue && !inflight_we_reg);
         c_wr_req_reg <= (issue &&  we_mem[rd_ptr_reg]) || (reissue &&  inflight_we_reg);

         if (issue) begin
            rd_ptr_reg      <= rd_ptr_reg + PTR_W'(1);
            c_addr_reg      <= addr_mem[rd_ptr_reg];
            c_data_in_reg   <= data_mem[rd_ptr_reg];
            inflight_we_reg <= we_mem[rd_ptr_reg];
            reissued_reg    <= 1'b0;
         end else if (reissue) begin
            reissued_reg <= 1'b1;
         end

         // The pulse cycle itself counts as the first idle cycle of the controller.
         if (state_reg == WAIT_BUSY && c_rdy) begin
            wait_cnt_reg <= wait_cnt_reg + 3'd1;
         end else begin
            wait_cnt_reg <= '0;
         end

         h_rvalid_reg <= done && !inflight_we_reg;
         if (done && !inflight_we_reg) begin
            h_rdata_reg <= c_data_out;
         end
      end
   end

   assign h_ready   = ready_reg;
   assign q_count   = count_reg;
   assign c_rd_req  = c_rd_req_reg;
   assign c_wr_req  = c_wr_req_reg;
   assign c_addr    = c_addr_reg;
   assign c_data_in = c_data_in_reg;
   assign h_rvalid  = h_rvalid_reg;
   assign h_rdata   = h_rdata_reg;

endmodule

// File: tb/tb_ddr2_req_queue.sv
// Scoreboard bench for ddr2_req_queue: host driver plus controller model push expectations,
// a negedge monitor pops and compares every pulse, read return and queue status.
module tb_ddr2_req_queue;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 26;
   localparam int DATA_W = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              h_valid = 1'b0;
   logic              h_ready;
   logic              h_we = 1'b0;
   logic [ADDR_W-1:0] h_addr = '0;
   logic [DATA_W-1:0] h_wdata = '0;
   logic              h_rvalid;
   logic [DATA_W-1:0] h_rdata;
   logic [2:0]        q_count;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_data_in;
   logic              c_rd_req;
   logic              c_wr_req;
   logic              c_rdy = 1'b1;
   logic [DATA_W-1:0] c_data_out = '0;

   ddr2_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_rvalid(h_rvalid), .h_rdata(h_rdata), .q_count(q_count),
      .c_addr(c_addr), .c_data_in(c_data_in), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req),
      .c_rdy(c_rdy), .c_data_out(c_data_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;

   req_t              issue_q[$];
   logic [DATA_W-1:0] rdata_q[$];
   int errors = 0;
   int checks = 0;

   // Reference model state: queue occupancy and request bookkeeping.
   int   model_count = 0;
   bit   exp_ready = 1'b0;
   bit   last_edge_rst = 1'b0;
   int   issued_cnt = 0;
   int   completions = 0;
   int   reissues = 0;
   req_t cur = '0;
   int   cyc = 0;
   int   last_pulse_cyc = -100;

   // Controller model state.
   int   cst = 0;
   int   busy_left = 0;
   int   busy_len = 4;
   bit   hold = 1'b0;
   bit   ignore_next = 1'b0;
   bit   rand_busy = 1'b0;
   bit   cur_rd = 1'b0;
   bit   use_fixed = 1'b0;
   logic [DATA_W-1:0] fixed_rdata = '0;
   bit   last_acc = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (last_edge_rst) begin
         chk("rst_q_count", 64'(q_count), 64'd0);
         chk("rst_h_ready", 64'(h_ready), 64'd0);
         chk("rst_c_rd_req", 64'(c_rd_req), 64'd0);
         chk("rst_c_wr_req", 64'(c_wr_req), 64'd0);
         chk("rst_h_rvalid", 64'(h_rvalid), 64'd0);
         chk("rst_c_addr", 64'(c_addr), 64'd0);
         chk("rst_c_data_in", c_data_in, 64'd0);
         chk("rst_h_rdata", h_rdata, 64'd0);
         exp_ready = 1'b0;
      end else begin
         chk("req_exclusive", 64'(c_rd_req & c_wr_req), 64'd0);
         if (c_rd_req || c_wr_req) begin
            if (issued_cnt > completions) begin
               reissues++;
               $display("txn reissue we=%0d addr=%h", c_wr_req, c_addr);
               chk("reissue_we", 64'(c_wr_req), 64'(cur.we));
               chk("reissue_addr", 64'(c_addr), 64'(cur.addr));
               chk("reissue_gap", 64'((cyc - last_pulse_cyc) >= 8 && (cyc - last_pulse_cyc) <= 9), 64'd1);
            end else if (issue_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: got rd=%0d wr=%0d addr=%h required no pulse", c_rd_req, c_wr_req, c_addr);
            end else begin
               cur = issue_q.pop_front();
               $display("txn issue we=%0d addr=%h data=%h", c_wr_req, c_addr, c_data_in);
               chk("issue_we", 64'(c_wr_req), 64'(cur.we));
               chk("issue_addr", 64'(c_addr), 64'(cur.addr));
               if (cur.we) chk("issue_wdata", c_data_in, cur.data);
               chk("pulse_spacing", 64'((cyc - last_pulse_cyc) >= 3), 64'd1);
               issued_cnt++;
               model_count--;
            end
            last_pulse_cyc = cyc;
         end else if (issued_cnt > completions) begin
            chk("hold_addr", 64'(c_addr), 64'(cur.addr));
            if (cur.we) chk("hold_wdata", c_data_in, cur.data);
         end
         if (h_rvalid) begin
            if (rdata_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rvalid: got h_rdata=%h required no h_rvalid", h_rdata);
            end else begin
               logic [DATA_W-1:0] e;
               e = rdata_q.pop_front();
               $display("txn read_return data=%h", h_rdata);
               chk("rdata", h_rdata, e);
            end
         end
         chk("q_count", 64'(q_count), 64'(model_count));
         chk("h_ready", 64'(h_ready), 64'(model_count < DEPTH));
         exp_ready = (model_count < DEPTH);
      end
   end

   task automatic ctrl_step();
      case (cst)
         0: begin
            c_rdy = !hold;
            if (c_rd_req || c_wr_req) begin
               if (ignore_next) begin
                  ignore_next = 1'b0;
               end else begin
                  cst = 1;
                  cur_rd = c_rd_req;
               end
            end
         end
         1: begin
            c_rdy = 1'b0;
            busy_left = rand_busy ? int'($urandom_range(1, 5)) : busy_len;
            cst = 2;
         end
         default: begin
            if (busy_left > 1) begin
               busy_left--;
            end else if (!hold) begin
               c_rdy = 1'b1;
               c_data_out = use_fixed ? fixed_rdata : {$urandom, $urandom};
               if (cur_rd) rdata_q.push_back(c_data_out);
               completions++;
               cst = 0;
            end
         end
      endcase
   endtask

   task automatic step();
      bit was_rst;
      @(posedge clk);
      #1;
      was_rst = !rst_n;
      last_acc = 1'b0;
      if (was_rst) begin
         model_count = 0;
         issue_q.delete();
         rdata_q.delete();
         issued_cnt = 0;
         completions = 0;
         cst = 0;
         c_rdy = 1'b1;
         hold = 1'b0;
         ignore_next = 1'b0;
      end else if (h_valid && exp_ready) begin
         issue_q.push_back(req_t'({h_we, h_addr, h_wdata}));
         model_count++;
         last_acc = 1'b1;
      end
      last_edge_rst = was_rst;
      if (!was_rst) ctrl_step();
   endtask

   task automatic send(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int tries;
      h_valid = 1'b1;
      h_we = we;
      h_addr = a;
      h_wdata = d;
      tries = 0;
      step();
      while (!last_acc && tries < 200) begin
         tries++;
         step();
      end
      h_valid = 1'b0;
      if (!last_acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no acceptance after %0d cycles required acceptance", tries);
      end
   endtask

   task automatic drain();
      int n;
      h_valid = 1'b0;
      n = 0;
      while (n < 3000 && !(issue_q.size() == 0 && rdata_q.size() == 0 &&
                           issued_cnt == completions && cst == 0 && model_count == 0)) begin
         n++;
         step();
      end
      repeat (3) step();
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending required 0", issue_q.size() + rdata_q.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r0;
      int n;
      // Reset held with h_valid asserted.
      rst_n = 1'b0;
      h_valid = 1'b1;
      h_addr = 26'h55;
      repeat (3) step();
      rst_n = 1'b1;
      h_valid = 1'b0;
      step();

      // Single write, then a read at the top address.
      busy_len = 4;
      send(1'b1, 26'h0000123, 64'hDEADBEEF_CAFEF00D);
      drain();
      use_fixed = 1'b1;
      fixed_rdata = 64'h0123456789ABCDEF;
      send(1'b0, 26'h3FFFFFF, 64'h0);
      drain();
      use_fixed = 1'b0;

      // Fill with controller busy: five offered, four accepted.
      hold = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         h_valid = 1'b1;
         h_we = i[0];
         h_addr = ADDR_W'(26'h100 + i);
         h_wdata = {$urandom, $urandom};
         step();
      end
      h_valid = 1'b0;
      step();
      chk("fill_q_count", 64'(q_count), 64'd4);
      chk("fill_h_ready", 64'(h_ready), 64'd0);
      hold = 1'b0;
      drain();

      // Alternating W/R stream then random traffic.
      rand_busy = 1'b1;
      for (int i = 0; i < 24; i++) begin
         send(i[0] == 1'b0, ADDR_W'($urandom), {$urandom, $urandom});
      end
      for (int i = 0; i < 400; i++) begin
         h_valid = ($urandom_range(0, 99) < 70);
         h_we = $urandom_range(0, 1) == 1;
         h_addr = ADDR_W'($urandom);
         h_wdata = {$urandom, $urandom};
         step();
      end
      drain();

      // Ignored pulse: one re-issue, then reset while waiting for completion.
      rand_busy = 1'b0;
      busy_len = 3;
      r0 = reissues;
      ignore_next = 1'b1;
      send(1'b0, 26'h2A5A5A5, 64'h0);
      n = 0;
      while (cst != 2 && n < 60) begin
         n++;
         step();
      end
      chk("reissue_count", 64'(reissues - r0), 64'd1);
      hold = 1'b1;
      repeat (2) step();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      repeat (20) step();
      send(1'b0, 26'h0000042, 64'h0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
